// File: rtl/seg7_mux_counter.sv
// seg7_mux_counter: N-digit up/down BCD counter with a programmable tick
// prescaler and a time-multiplexed common-cathode seven-segment scanner.
module seg7_mux_counter #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned DIV_W         = 24,
    parameter int unsigned DEFAULT_DIV   = 10_000_000,
    parameter int unsigned REFRESH_DIV   = 10_000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [15:0]               div_in,
    input  logic                      enable,
    input  logic                      up_dn,
    input  logic                      clear,
    output logic [6:0]                segments,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     digit_sel,
    output logic [4*NUM_DIGITS-1:0]   count_bcd,
    output logic                      wrap
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned REF_W = $clog2(REFRESH_DIV);

    logic [DIV_W-1:0]        div;
    logic                    tick;
    logic [DIV_W-1:0]        pre_q, pre_d;
    logic [4*NUM_DIGITS-1:0] count_q, count_d, stepped;
    logic                    carry;
    logic                    wrap_q, wrap_d;
    logic                    dps_q, dps_d;
    logic [REF_W-1:0]        ref_q, ref_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [3:0]              cur_digit;
    logic                    upper_nz;
    logic                    blank;

    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'd0:    enc = 7'h3F;
            4'd1:    enc = 7'h06;
            4'd2:    enc = 7'h5B;
            4'd3:    enc = 7'h4F;
            4'd4:    enc = 7'h66;
            4'd5:    enc = 7'h6D;
            4'd6:    enc = 7'h7D;
            4'd7:    enc = 7'h07;
            4'd8:    enc = 7'h7F;
            4'd9:    enc = 7'h6F;
            default: enc = 7'h00;
        endcase
    endfunction

    // Prescaler: >= compare so a shortened period ticks at once instead of wrapping.
    always_comb begin
        div   = (div_in == 16'd0) ? DIV_W'(DEFAULT_DIV) : DIV_W'({div_in, 8'h00});
        tick  = (pre_q >= div - DIV_W'(1));
        pre_d = tick ? '0 : pre_q + DIV_W'(1);
        dps_d = dps_q ^ tick;
    end

    // BCD counter: ripple carry/borrow across digits; final carry marks a wrap.
    always_comb begin
        stepped = count_q;
        carry   = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (up_dn) begin
                    if (count_q[4*i +: 4] == 4'd9) begin
                        stepped[4*i +: 4] = 4'd0;
                    end else begin
                        stepped[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                        carry             = 1'b0;
                    end
                end else begin
                    if (count_q[4*i +: 4] == 4'd0) begin
                        stepped[4*i +: 4] = 4'd9;
                    end else begin
                        stepped[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                        carry             = 1'b0;
                    end
                end
            end
        end
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (tick && enable) begin
            count_d = stepped;
            wrap_d  = carry;
        end
    end

    // Scanner: select current digit, decide leading-zero blanking, advance scan.
    always_comb begin
        cur_digit = 4'd0;
        upper_nz  = 1'b0;
        sel_d     = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == idx_q) begin
                cur_digit = count_q[4*i +: 4];
                sel_d[i]  = 1'b1;
            end
            if (IDX_W'(i) >= idx_q && count_q[4*i +: 4] != 4'd0) begin
                upper_nz = 1'b1;
            end
        end
        blank = BLANK_LEADING && (idx_q != '0) && !upper_nz;
        seg_d = blank ? '0 : enc(cur_digit);
        dp_d  = (idx_q == '0) && dps_q;
        ref_d = ref_q + 1'b1;
        idx_d = idx_q;
        if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_d = '0;
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // State and output registers; synchronous reset dominates.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q   <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
            dps_q   <= 1'b0;
            ref_q   <= '0;
            idx_q   <= '0;
            sel_q   <= NUM_DIGITS'(1);
            seg_q   <= 7'h3F;
            dp_q    <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            dps_q   <= dps_d;
            ref_q   <= ref_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign segments  = seg_q;
    assign dp        = dp_q;
    assign digit_sel = sel_q;
    assign count_bcd = count_q;
    assign wrap      = wrap_q;

endmodule
